// File: rtl/gpioemu_prime_engine_if.sv
// Bus/GPIO shim signals of the N-th-prime coprocessor.
// The host drives the master side; the engine uses the slave side.
interface gpioemu_prime_engine_if #(
    parameter int DATA_W = 32
);
    logic [15:0]       saddress;
    logic              swr;
    logic              srd;
    logic [DATA_W-1:0] sdata_in;
    logic [DATA_W-1:0] sdata_out;
    logic [DATA_W-1:0] gpio_out;
    logic              busy;
    logic              irq;

    modport master (
        output saddress, swr, srd, sdata_in,
        input  sdata_out, gpio_out, busy, irq
    );

    modport slave (
        input  saddress, swr, srd, sdata_in,
        output sdata_out, gpio_out, busy, irq
    );
endinterface

// File: rtl/gpioemu_prime_engine.sv
// N-th-prime coprocessor: trial-division search filling an on-chip prime table.
// Define GPIOEMU_PRIME_CACHE_EN to keep the table and candidate across runs.
module gpioemu_prime_engine #(
    parameter logic [15:0] BASE    = 16'h0258,
    parameter int          IDX_W   = 10,
    parameter int          PRIME_W = 16,
    parameter int          DATA_W  = 32
) (
    input  logic                   clk,
    input  logic                   n_reset,
    gpioemu_prime_engine_if.slave  bus
);
    localparam int          CNT_W    = IDX_W + 1;
    localparam logic [15:0] ADDR_RES = BASE + 16'h0010;
    localparam logic [15:0] ADDR_STA = BASE + 16'h0018;
    localparam logic [15:0] ADDR_CNT = BASE + 16'h0020;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOOKUP = 2'd2
    } state_t;

    state_t               state_r;
    logic [PRIME_W-1:0]   primes_r [2**IDX_W];
    logic [IDX_W-1:0]     n_r;
    logic [CNT_W-1:0]     count_r;
    logic [PRIME_W-1:0]   cand_r;
    logic [CNT_W-1:0]     j_r;
    logic [PRIME_W-1:0]   result_r;
    logic                 error_r;
    logic                 overrun_r;
    logic                 busy_r;
    logic                 irq_r;
    logic [15:0]          run_cnt_r;
    logic [DATA_W-1:0]    sdata_out_r;

    logic [PRIME_W-1:0]   pj_s;
    logic [PRIME_W-1:0]   plook_s;
    logic [IDX_W-1:0]     look_idx_s;
    logic [2*PRIME_W-1:0] sq_s;
    logic [PRIME_W:0]     cand_next_s;
    logic                 is_prime_s;
    logic                 divides_s;
    logic                 cand_ovf_s;
    logic                 found_s;
    logic                 wr_s;
    logic [IDX_W-1:0]     wdata_s;
    logic [CNT_W-1:0]     count_start_s;
    logic                 sdata_unused_s;

    assign sdata_unused_s = ^bus.sdata_in[DATA_W-1:IDX_W];

    // Divisor test, table lookup and start decision for the current cycle
    always_comb begin
        wdata_s     = bus.sdata_in[IDX_W-1:0];
        wr_s        = bus.swr && (bus.saddress == BASE);
        look_idx_s  = n_r - {{(IDX_W-1){1'b0}}, 1'b1};
        if (j_r == {CNT_W{1'b0}}) begin
            pj_s = PRIME_W'(2);
        end else begin
            pj_s = primes_r[j_r[IDX_W-1:0]];
        end
        // primes[0] is the constant 2 and never stored in the array
        if (look_idx_s == {IDX_W{1'b0}}) begin
            plook_s = PRIME_W'(2);
        end else begin
            plook_s = primes_r[look_idx_s];
        end
        sq_s        = {{PRIME_W{1'b0}}, pj_s} * {{PRIME_W{1'b0}}, pj_s};
        is_prime_s  = (j_r == count_r) || (sq_s > {{PRIME_W{1'b0}}, cand_r});
        divides_s   = (pj_s != {PRIME_W{1'b0}}) && ((cand_r % pj_s) == {PRIME_W{1'b0}});
        cand_next_s = {1'b0, cand_r} + {{PRIME_W{1'b0}}, 1'b1, 1'b0};
        cand_ovf_s  = cand_next_s > {1'b0, {PRIME_W{1'b1}}};
        found_s     = (count_r + {{(CNT_W-1){1'b0}}, 1'b1}) == {1'b0, n_r};
`ifdef GPIOEMU_PRIME_CACHE_EN
        count_start_s = count_r;
`else
        count_start_s = {{(CNT_W-1){1'b0}}, 1'b1};
`endif
    end

    // Prime table storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if ((state_r == ST_SEARCH) && is_prime_s) begin
            primes_r[count_r[IDX_W-1:0]] <= cand_r;
        end
    end

    // Control FSM, status flags, run counter and registered bus read data
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r     <= ST_IDLE;
            n_r         <= {IDX_W{1'b0}};
            count_r     <= {{(CNT_W-1){1'b0}}, 1'b1};
            cand_r      <= PRIME_W'(3);
            j_r         <= {{(CNT_W-1){1'b0}}, 1'b1};
            result_r    <= {PRIME_W{1'b0}};
            error_r     <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
            irq_r       <= 1'b0;
            run_cnt_r   <= 16'd0;
            sdata_out_r <= {DATA_W{1'b0}};
        end else begin
            irq_r <= 1'b0;
            // Reads see the state before this edge's updates
            if (bus.srd) begin
                case (bus.saddress)
                    ADDR_RES: sdata_out_r <= busy_r ? {(DATA_W/2){2'b10}} : DATA_W'(result_r);
                    ADDR_STA: sdata_out_r <= DATA_W'({overrun_r, error_r, busy_r});
                    ADDR_CNT: sdata_out_r <= DATA_W'(run_cnt_r);
                    default:  sdata_out_r <= {DATA_W{1'b0}};
                endcase
            end
            case (state_r)
                ST_IDLE: begin
                    if (wr_s) begin
                        overrun_r <= 1'b0;
                        n_r       <= wdata_s;
                        if (wdata_s == {IDX_W{1'b0}}) begin
                            error_r  <= 1'b1;
                            result_r <= {PRIME_W{1'b0}};
                            irq_r    <= 1'b1;
                        end else begin
                            error_r <= 1'b0;
                            busy_r  <= 1'b1;
`ifndef GPIOEMU_PRIME_CACHE_EN
                            count_r <= {{(CNT_W-1){1'b0}}, 1'b1};
                            cand_r  <= PRIME_W'(3);
`endif
                            if ({1'b0, wdata_s} <= count_start_s) begin
                                state_r <= ST_LOOKUP;
                            end else begin
                                state_r <= ST_SEARCH;
                                j_r     <= {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                end
                ST_SEARCH: begin
                    if (wr_s) begin
                        overrun_r <= 1'b1;
                    end
                    if (is_prime_s || divides_s) begin
                        j_r <= {{(CNT_W-1){1'b0}}, 1'b1};
                        if (is_prime_s) begin
                            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        // Finding the N-th prime wins over the candidate overflow
                        if (is_prime_s && found_s) begin
                            state_r <= ST_LOOKUP;
                            if (!cand_ovf_s) begin
                                cand_r <= cand_next_s[PRIME_W-1:0];
                            end
                        end else if (cand_ovf_s) begin
                            error_r  <= 1'b1;
                            result_r <= {PRIME_W{1'b0}};
                            busy_r   <= 1'b0;
                            irq_r    <= 1'b1;
                            state_r  <= ST_IDLE;
                        end else begin
                            cand_r <= cand_next_s[PRIME_W-1:0];
                        end
                    end else begin
                        j_r <= j_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_LOOKUP: begin
                    if (wr_s) begin
                        overrun_r <= 1'b1;
                    end
                    result_r  <= plook_s;
                    busy_r    <= 1'b0;
                    irq_r     <= 1'b1;
                    run_cnt_r <= run_cnt_r + 16'd1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sdata_out = sdata_out_r;
    assign bus.gpio_out  = DATA_W'(run_cnt_r);
    assign bus.busy      = busy_r;
    assign bus.irq       = irq_r;

endmodule

// File: tb/tb_gpioemu_prime_engine.sv
// Self-checking bench for gpioemu_prime_engine: constant vector table,
// hand-written corner sequences and random N checked against a prime model.
module tb_gpioemu_prime_engine;
    localparam logic [15:0] BASE     = 16'h0258;
    localparam logic [15:0] ADDR_RES = 16'h0268;
    localparam logic [15:0] ADDR_STA = 16'h0270;
    localparam logic [15:0] ADDR_CNT = 16'h0278;
    localparam logic [31:0] BUSY_PAT = 32'hAAAAAAAA;

    logic clk = 1'b0;
    logic n_reset = 1'b0;

    gpioemu_prime_engine_if #(.DATA_W(32)) bus ();

    gpioemu_prime_engine dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int irq_cnt  = 0;
    int run_exp  = 0;
    int ref_primes [1024];

    typedef struct {
        int n;
        int exp_res;
    } vec_t;
    vec_t vecs [5];

    always @(negedge clk) begin
        if (bus.irq) irq_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input int n);
        @(negedge clk);
        bus.saddress = BASE;
        bus.sdata_in = n;
        bus.swr      = 1'b1;
        @(posedge clk);
        #1;
        bus.swr = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.saddress = a;
        bus.srd      = 1'b1;
        @(posedge clk);
        #1;
        bus.srd = 1'b0;
        d = bus.sdata_out;
    endtask

    task automatic wait_idle(input int budget, output int cyc);
        cyc = 0;
        while (bus.busy && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("wait_idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_and_check(input string name, input int n, input int exp_res);
        logic [31:0] d;
        int          cyc;
        int          irq0;
        irq0 = irq_cnt;
        wr(n);
        rd(ADDR_RES, d);
        check({name, "_busy_read"}, d, BUSY_PAT);
        wait_idle(40000, cyc);
        rd(ADDR_RES, d);
        check({name, "_result"}, d, exp_res);
        rd(ADDR_STA, d);
        check({name, "_status"}, d, 32'd0);
        run_exp++;
        rd(ADDR_CNT, d);
        check({name, "_count"}, d, run_exp);
        check({name, "_gpio"}, bus.gpio_out, run_exp);
        check({name, "_irq_pulses"}, irq_cnt - irq0, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int          cyc;
        int          irq0;
        int          k;
        int          cnt;
        bit          isp;

        // Reference model: N-th primes by plain trial division over all integers
        cnt = 0;
        k   = 2;
        while (cnt < 1024) begin
            isp = 1'b1;
            for (int dv = 2; dv * dv <= k; dv++) begin
                if (k % dv == 0) isp = 1'b0;
            end
            if (isp) begin
                ref_primes[cnt] = k;
                cnt++;
            end
            k++;
        end

        vecs[0] = '{n: 10,  exp_res: 29};
        vecs[1] = '{n: 2,   exp_res: 3};
        vecs[2] = '{n: 25,  exp_res: 97};
        vecs[3] = '{n: 100, exp_res: 541};
        vecs[4] = '{n: 168, exp_res: 997};

        bus.saddress = 16'd0;
        bus.sdata_in = 32'd0;
        bus.swr      = 1'b0;
        bus.srd      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_sdata_out", bus.sdata_out, 32'd0);
        check("reset_gpio_out", bus.gpio_out, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_irq", {31'd0, bus.irq}, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;

        // N=1: single-cycle lookup timing
        irq0 = irq_cnt;
        wr(1);
        check("n1_busy_after_k", {31'd0, bus.busy}, 32'd1);
        check("n1_irq_after_k", {31'd0, bus.irq}, 32'd0);
        @(posedge clk);
        #1;
        check("n1_busy_after_k1", {31'd0, bus.busy}, 32'd0);
        check("n1_irq_after_k1", {31'd0, bus.irq}, 32'd1);
        @(posedge clk);
        #1;
        check("n1_irq_after_k2", {31'd0, bus.irq}, 32'd0);
        run_exp++;
        rd(ADDR_RES, d);
        check("n1_result", d, 32'd2);
        rd(ADDR_STA, d);
        check("n1_status", d, 32'd0);
        rd(ADDR_CNT, d);
        check("n1_count", d, 32'd1);
        check("n1_irq_pulses", irq_cnt - irq0, 32'd1);

        for (int i = 0; i < 5; i++) begin
            check($sformatf("vec%0d_model", i), ref_primes[vecs[i].n - 1], vecs[i].exp_res);
            run_and_check($sformatf("vec%0d_n%0d", i, vecs[i].n), vecs[i].n, vecs[i].exp_res);
        end

        run_and_check("n1000", 1000, 7919);

        // N=5 after the table is full: 1-cycle lookup only with the cache
        wr(5);
`ifdef GPIOEMU_PRIME_CACHE_EN
        @(posedge clk);
        #1;
        check("n5_cached_done_in_1", {31'd0, bus.busy}, 32'd0);
`else
        wait_idle(40000, cyc);
        check("n5_multicycle", {31'd0, cyc > 1}, 32'd1);
`endif
        wait_idle(40000, cyc);
        run_exp++;
        rd(ADDR_RES, d);
        check("n5_result", d, 32'd11);

        // Start while busy is ignored and flags overrun
        irq0 = irq_cnt;
        wr(500);
        wr(3);
        wait_idle(40000, cyc);
        run_exp++;
        rd(ADDR_RES, d);
        check("overrun_result", d, 32'd3571);
        rd(ADDR_STA, d);
        check("overrun_status", d, 32'd4);
        check("overrun_irq_pulses", irq_cnt - irq0, 32'd1);
        run_and_check("overrun_clear_n2", 2, 3);

        // N=0: error, irq, no busy, run counter unchanged
        irq0 = irq_cnt;
        wr(0);
        check("n0_busy", {31'd0, bus.busy}, 32'd0);
        check("n0_irq", {31'd0, bus.irq}, 32'd1);
        rd(ADDR_STA, d);
        check("n0_status", d, 32'd2);
        rd(ADDR_RES, d);
        check("n0_result", d, 32'd0);
        rd(ADDR_CNT, d);
        check("n0_count", d, run_exp);
        check("n0_irq_pulses", irq_cnt - irq0, 32'd1);

        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(150, 1);
            run_and_check($sformatf("rand%0d_n%0d", i, k), k, ref_primes[k - 1]);
        end

        rd(16'h0260, d);
        check("unmapped_read", d, 32'd0);

        // Asynchronous reset in the middle of a long search
        wr(800);
        repeat (50) @(posedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        check("midreset_sdata_out", bus.sdata_out, 32'd0);
        check("midreset_gpio_out", bus.gpio_out, 32'd0);
        check("midreset_busy", {31'd0, bus.busy}, 32'd0);
        check("midreset_irq", {31'd0, bus.irq}, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        run_exp = 0;
        run_and_check("post_reset_n4", 4, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpioemu_prime_engine.md
# gpioemu_prime_engine

Parametrised, clocked successor to the GPIO-emulated N-th-prime coprocessor. The host writes an index N over the emulated bus. A multi-cycle trial-division FSM finds the N-th prime and stores primes in an on-chip table, so results stay available for later lookups. The block sits behind the same bus/GPIO shim as the previous generation, adds status flags, an interrupt pulse and a run counter, and keeps the legacy register offsets.

## Interface
- BASE, 16'h258: bus address of the N (start) register; RESULT = BASE+'h10, STATUS = BASE+'h18, COUNT = BASE+'h20.
- IDX_W, 10: width of N; table depth is 2^IDX_W entries.
- PRIME_W, 16: width of a stored prime; must satisfy 2^PRIME_W > (2^IDX_W − 1)-th prime.
- DATA_W, 32: bus data width.
- clk  in  1  system clock, all logic on rising edge.
- n_reset  in  1  reset, asynchronous, active-low.
- saddress  in  16  bus address, sampled with strobes.
- swr  in  1  write strobe, one-cycle synchronous pulse.
- srd  in  1  read strobe, one-cycle synchronous pulse.
- sdata_in  in  DATA_W  write data; bits above IDX_W−1 ignored.
- sdata_out  out  DATA_W  registered read data; reset 0.
- gpio_out  out  DATA_W  {zeros, 16-bit completed-run counter}; reset 0.
- busy  out  1  high while a computation is in progress; reset 0.
- irq  out  1  one-cycle pulse on completion or error; reset 0.

## Operation
- Table: primes[0] is fixed at 2. Registers: count (valid entries, reset 1), cand (next odd candidate, reset 3), j (divisor index).
- States:
  - IDLE: swr to BASE latches N. N==0 sets error, pulses irq and stays IDLE. N ≤ count goes to LOOKUP. Otherwise goes to SEARCH with j=1.
  - LOOKUP: result = primes[N−1]; returns to IDLE and pulses irq.
  - SEARCH: performs one divisor test per cycle.
    - If j==count or primes[j]² > cand (2·PRIME_W-bit product): cand is prime. Store it at primes[count], increment count, cand += 2, j = 1.
    - Else if cand % primes[j] == 0: cand += 2, j = 1.
    - Else: j += 1.
    - When count reaches N, go to LOOKUP.
    - If cand += 2 would exceed 2^PRIME_W − 1: set error, result = 0, return to IDLE and pulse irq.
- swr to BASE while busy is ignored and sets overrun. An accepted start clears error and overrun.
- Reads, with sdata_out updated on the edge that samples srd:
  - RESULT: result zero-extended when idle; 32'hAAAAAAAA while busy.
  - STATUS: {zeros, overrun, error, busy} in bits [2:0].
  - COUNT: run counter.
  - Any other address: 0.
- Run counter increments on every successful completion, wraps at 16 bits, and excludes error runs.
- A simultaneous swr and srd on one edge is allowed. The read returns the pre-write state.
- Reset at any time aborts the operation. All outputs and flags return to 0, count returns to 1, cand to 3, run counter to 0. Table contents beyond index 0 are don't-care.

## Timing
- Start accepted at edge k; busy = 1 after edge k.
- LOOKUP path: result valid, busy = 0 and irq = 1 after edge k+1. irq drops after edge k+2.
- SEARCH path: one divisor test per cycle. Latency is data-dependent and bounded by the sum of divisor tests up to the N-th prime, plus 1 for LOOKUP.
- sdata_out is valid the cycle after the srd edge and holds until the next srd.
- N = 0: error = 1 and irq pulse after edge k; busy never asserts.

## Configuration
- GPIOEMU_PRIME_CACHE_EN defined: the table and cand persist across runs. A later N ≤ count completes in the 1-cycle LOOKUP.
- Undefined: every accepted start resets count to 1 and cand to 3, so each run recomputes from scratch. LOOKUP is reached only after SEARCH (N == 1 still goes straight to LOOKUP).

## Test plan
- Reset, then write N=1: result 2 after 1 cycle; STATUS = 0; COUNT = 1; one irq pulse.
- Write N=10, poll until busy = 0: RESULT = 29 (0x1D); reading RESULT while busy returns 0xAAAAAAAA.
- Write N=1000: RESULT = 7919. Then write N=5: with cache, result 11 exactly 1 cycle after the start; without cache, multi-cycle with the same value.
- Write N=500 and, while busy, write N=3: the second write is ignored; RESULT = 3571; STATUS bit2 = 1; the next accepted start clears it.
- Write N=0: STATUS = 0b010, RESULT = 0, irq pulses, COUNT unchanged.
- Assert n_reset mid-SEARCH for N=800: all outputs 0 immediately. After release, N=4 gives 7.
